fft_bitrev_reorder: RTL and testbench
=====================================

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: i_valid  input  1  input beat qualifier from FFT core (its o_valid).
REQ-004 SHALL have port: din_i  input  16 x 13 signed  real part, lanes 0..15, bit-reversed bin order.
REQ-005 SHALL have port: din_q  input  16 x 13 signed  imaginary part, lanes 0..15, bit-reversed bin order.
REQ-006 SHALL have port: o_valid  output  1  output beat qualifier.
REQ-007 SHALL have port: dout_i  output  16 x 13 signed  real part, natural bin order.
REQ-008 SHALL have port: dout_q  output  16 x 13 signed  imaginary part, natural bin order.
REQ-009 SHALL have parameters: N, 512, points per frame; BLK, 16, lanes per beat; W, 13, sample width.

Function
REQ-010 SHALL define a frame as 32 beats with i_valid=1; gaps with i_valid=0 are allowed and ignored.
REQ-011 SHALL treat input beat b (0..31), lane l as bin X[bitrev9(16b+l)].
REQ-012 SHALL present output beat b, lane l as X[16b+l]; dout_i and dout_q use the same mapping.
REQ-013 SHALL pass values unmodified: no scaling, rounding or saturation.
REQ-014 SHALL buffer ping-pong: two 512-entry banks of (I,Q). Write side: 5-bit wr_cnt, wr_bank bit.
REQ-015 SHALL increment wr_cnt on each i_valid beat. On the beat with wr_cnt=31: wrap to 0, toggle wr_bank, raise frame-done to the read side.
REQ-016 SHALL use read FSM states IDLE and READ. IDLE->READ on frame-done, latching rd_bank = completed bank. READ->IDLE after output beat 31 when no frame-done is pending.
REQ-017 SHALL go READ->READ with rd_cnt reset to 0 and rd_bank updated when frame-done coincides with the edge that registers output beat 31. This gives back-to-back frames with no o_valid gap.
REQ-018 SHALL register outputs. Latency: if the 32nd input beat is captured at edge E, output beat 0 is registered at E+1 and beat 31 at E+32. o_valid is high E+1..E+32 continuously.
REQ-019 SHALL hold dout_i/dout_q at their last value while o_valid=0.
REQ-020 SHALL need no back-pressure. A frame takes at least 32 cycles and a read exactly 32, so the write bank is never the bank being read.
REQ-021 SHALL discard nothing while input is continuous. Input arriving during READ goes to the other bank.

Reset
REQ-022 SHALL, on rstn=0, immediately clear o_valid, dout_i, dout_q (all lanes 0), wr_cnt, rd_cnt, wr_bank, rd_bank and frame-done, and put the FSM in IDLE.
REQ-023 SHALL abandon a partial frame or partial read on reset mid-operation. The first 32 valid beats after rstn deasserts form frame 0.
REQ-024 SHALL NOT reset bank memory contents.

Configuration
REQ-025 SHALL compile output port o_sof (1 bit) only when macro FFT_REORDER_SOF_EN is defined.
REQ-026 SHALL, with FFT_REORDER_SOF_EN defined, drive o_sof=1 exactly in the cycle of output beat 0 and 0 otherwise; o_sof resets to 0.
REQ-027 SHALL have no o_sof port or logic without FFT_REORDER_SOF_EN; all other behaviour is identical.

Verification
REQ-028 SHALL cover: 32 contiguous beats, din_i lane l of beat b = bitrev9(16b+l), din_q = negated value -> o_valid for 32 cycles, dout_i[l] = 16b+l, dout_q[l] = -(16b+l), beat 0 one edge after the last input edge.
REQ-029 SHALL cover: same frame with a 1-cycle i_valid=0 gap after every 4th beat -> identical output; latency measured from the 32nd valid beat.
REQ-030 SHALL cover: two frames back-to-back (64 contiguous beats; frame 1 values +1000) -> 64 contiguous o_valid cycles, second 32 equal to 1000+16b+l.
REQ-031 SHALL cover: rstn low for 2 cycles after 10 beats, then a full frame -> outputs all 0 with o_valid=0 during and after reset; the following read matches the full frame only.
REQ-032 SHALL cover: bins 0 and 511 set to -4096 and +4095, others 0 -> dout_i[0] of beat 0 = -4096, dout_i[15] of beat 31 = 4095.
REQ-033 SHALL cover, with FFT_REORDER_SOF_EN defined: o_sof=1 only coincident with beat 0 of each frame; with the macro undefined, no o_sof port is present.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output beats (BLK lanes per beat) into natural bin order via ping-pong banks.
// Optional start-of-frame output o_sof is compiled in when FFT_REORDER_SOF_EN is defined.
module fft_bitrev_reorder #(
   parameter int N   = 512,
   parameter int BLK = 16,
   parameter int W   = 13
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   i_valid,
   input  logic [BLK-1:0][W-1:0]  din_i,
   input  logic [BLK-1:0][W-1:0]  din_q,
   output logic                   o_valid,
   output logic [BLK-1:0][W-1:0]  dout_i,
   output logic [BLK-1:0][W-1:0]  dout_q
`ifdef FFT_REORDER_SOF_EN
  ,output logic                   o_sof
`endif
);

   localparam int AW = $clog2(N);
   localparam int LW = $clog2(BLK);
   localparam int CW = AW - LW;
   localparam logic [CW-1:0] LAST_BEAT = CW'(N / BLK - 1);

   typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_e;

   function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      r = '0;
      for (int k = 0; k < AW; k++) r[k] = a[AW-1-k];
      return r;
   endfunction

   logic [W-1:0] mem_i_q [2][N];
   logic [W-1:0] mem_q_q [2][N];

   logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, rd_sel_beat_s;
   logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rd_sel_bank_s;
   logic          frame_done_q, frame_done_d, wr_done_s, emit_s, consume_q_s, consume_w_s;
   rd_state_e     state_q, state_d;
   logic          o_valid_q, o_valid_d, sof_q, sof_d;
   logic [BLK-1:0][W-1:0] dout_i_q, dout_i_d, dout_q_q, dout_q_d;

   // Memory write: lane l of beat b lands at its natural bin address.
   always_ff @(posedge clk) begin
      if (i_valid) begin
         for (int l = 0; l < BLK; l++) begin
            mem_i_q[wr_bank_q][bitrev({wr_cnt_q, LW'(l)})] <= din_i[l];
            mem_q_q[wr_bank_q][bitrev({wr_cnt_q, LW'(l)})] <= din_q[l];
         end
      end
   end

   // Write-side counters and frame completion.
   always_comb begin
      wr_done_s = i_valid && (wr_cnt_q == LAST_BEAT);
      wr_cnt_d  = i_valid ? wr_cnt_q + CW'(1) : wr_cnt_q;
      wr_bank_d = wr_done_s ? ~wr_bank_q : wr_bank_q;
   end

   // Read FSM: a frame that completes on the edge of output beat 31 continues READ without a gap.
   always_comb begin
      state_d       = state_q;
      rd_cnt_d      = rd_cnt_q;
      rd_bank_d     = rd_bank_q;
      emit_s        = 1'b0;
      rd_sel_bank_s = rd_bank_q;
      rd_sel_beat_s = rd_cnt_q;
      consume_q_s   = 1'b0;
      consume_w_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_done_q) begin
               emit_s        = 1'b1;
               rd_sel_bank_s = ~wr_bank_q;
               rd_sel_beat_s = '0;
               rd_bank_d     = ~wr_bank_q;
               rd_cnt_d      = CW'(1);
               state_d       = READ;
               consume_q_s   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            emit_s   = 1'b1;
            rd_cnt_d = rd_cnt_q + CW'(1);
            if (rd_cnt_q == LAST_BEAT) begin
               if (wr_done_s) begin
                  rd_bank_d   = wr_bank_q;
                  consume_w_s = 1'b1;
               end else if (frame_done_q) begin
                  rd_bank_d   = ~wr_bank_q;
                  consume_q_s = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase
      frame_done_d = (frame_done_q && !consume_q_s) || (wr_done_s && !consume_w_s);
   end

   // Output data selection; outputs hold while no beat is emitted.
   always_comb begin
      o_valid_d = emit_s;
      sof_d     = emit_s && (rd_sel_beat_s == '0);
      for (int l = 0; l < BLK; l++) begin
         if (emit_s) begin
            dout_i_d[l] = mem_i_q[rd_sel_bank_s][{rd_sel_beat_s, LW'(l)}];
            dout_q_d[l] = mem_q_q[rd_sel_bank_s][{rd_sel_beat_s, LW'(l)}];
         end else begin
            dout_i_d[l] = dout_i_q[l];
            dout_q_d[l] = dout_q_q[l];
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt_q     <= '0;
         wr_bank_q    <= 1'b0;
         frame_done_q <= 1'b0;
         state_q      <= IDLE;
         rd_cnt_q     <= '0;
         rd_bank_q    <= 1'b0;
         o_valid_q    <= 1'b0;
         sof_q        <= 1'b0;
         dout_i_q     <= '0;
         dout_q_q     <= '0;
      end else begin
         wr_cnt_q     <= wr_cnt_d;
         wr_bank_q    <= wr_bank_d;
         frame_done_q <= frame_done_d;
         state_q      <= state_d;
         rd_cnt_q     <= rd_cnt_d;
         rd_bank_q    <= rd_bank_d;
         o_valid_q    <= o_valid_d;
         sof_q        <= sof_d;
         dout_i_q     <= dout_i_d;
         dout_q_q     <= dout_q_d;
      end
   end

   assign o_valid = o_valid_q;
   assign dout_i  = dout_i_q;
   assign dout_q  = dout_q_q;
`ifdef FFT_REORDER_SOF_EN
   assign o_sof   = sof_q;
`else
   logic unused_sof_s;
   assign unused_sof_s = sof_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: natural-order frame model, per-cycle output checks.
module tb_fft_bitrev_reorder;
   localparam int N   = 512;
   localparam int BLK = 16;
   localparam int W   = 13;
   localparam int MAXF = 32;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic i_valid = 1'b0;
   logic [BLK-1:0][W-1:0] din_i, din_q, dout_i, dout_q;
   logic o_valid;
`ifdef FFT_REORDER_SOF_EN
   logic o_sof;
`endif

   always #5 clk = ~clk;

   fft_bitrev_reorder #(.N(N), .BLK(BLK), .W(W)) dut (
      .clk(clk), .rstn(rstn), .i_valid(i_valid),
      .din_i(din_i), .din_q(din_q),
      .o_valid(o_valid), .dout_i(dout_i), .dout_q(dout_q)
`ifdef FFT_REORDER_SOF_EN
     ,.o_sof(o_sof)
`endif
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int cur_i [N];
   int cur_q [N];
   int fr_i [MAXF][N];
   int fr_q [MAXF][N];
   int done_edge [MAXF];
   int nfr = 0;
   int first_live = 0;
   int beats_in = 0;
   logic [BLK*W-1:0] last_i = '0;
   logic [BLK*W-1:0] last_q = '0;

   task automatic check_eq(input string tag, input logic [BLK*W-1:0] act, input logic [BLK*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask

   function automatic int bitrev9(input int v);
      int r = 0;
      for (int k = 0; k < 9; k++) r = r * 2 + ((v >> k) & 1);
      return r;
   endfunction

   task automatic junk_din();
      for (int l = 0; l < BLK; l++) begin
         din_i[l] = W'($urandom);
         din_q[l] = W'($urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_valid = 1'b0;
         junk_din();
      end
   endtask

   task automatic send_beat(input int b);
      @(negedge clk);
      i_valid = 1'b1;
      for (int l = 0; l < BLK; l++) begin
         din_i[l] = W'(cur_i[bitrev9(16 * b + l)]);
         din_q[l] = W'(cur_q[bitrev9(16 * b + l)]);
      end
      beats_in++;
      if (beats_in == 32) begin
         beats_in = 0;
         if (nfr < MAXF) begin
            for (int n = 0; n < N; n++) begin
               fr_i[nfr][n] = cur_i[n];
               fr_q[nfr][n] = cur_q[n];
            end
            done_edge[nfr] = cyc + 1;
            nfr++;
         end
      end
   endtask

   task automatic send_frame(input int gap_every, input bit rnd_gaps);
      for (int b = 0; b < 32; b++) begin
         send_beat(b);
         if (b != 31) begin
            if (gap_every > 0 && ((b + 1) % gap_every) == 0) idle(1);
            if (rnd_gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
   endtask

   task automatic fill_ramp(input int off);
      for (int n = 0; n < N; n++) begin
         cur_i[n] = off + n;
         cur_q[n] = -(off + n);
      end
   endtask

   task automatic fill_rand();
      for (int n = 0; n < N; n++) begin
         cur_i[n] = int'($urandom_range(0, 8191)) - 4096;
         cur_q[n] = int'($urandom_range(0, 8191)) - 4096;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rstn = 1'b0;
      i_valid = 1'b0;
      junk_din();
      first_live = nfr;
      beats_in = 0;
      last_i = '0;
      last_q = '0;
      repeat (n) @(negedge clk);
      rstn = 1'b1;
   endtask

   // Per-edge monitor: expected o_valid window and data come from the recorded frames.
   always begin
      logic found;
      int   kf, b;
      logic [BLK*W-1:0] ei, eq;
      @(posedge clk);
      #1;
      cyc++;
      found = 1'b0;
      kf = 0;
      b = 0;
      for (int k = first_live; k < nfr; k++) begin
         if (cyc >= done_edge[k] + 1 && cyc <= done_edge[k] + 32) begin
            found = 1'b1;
            kf = k;
            b = cyc - done_edge[k] - 1;
         end
      end
      check_eq("o_valid", {{(BLK*W-1){1'b0}}, o_valid}, {{(BLK*W-1){1'b0}}, found});
`ifdef FFT_REORDER_SOF_EN
      check_eq("o_sof", {{(BLK*W-1){1'b0}}, o_sof}, {{(BLK*W-1){1'b0}}, (found && b == 0)});
`endif
      if (found) begin
         for (int l = 0; l < BLK; l++) begin
            ei[l*W +: W] = W'(fr_i[kf][16 * b + l]);
            eq[l*W +: W] = W'(fr_q[kf][16 * b + l]);
         end
         last_i = ei;
         last_q = eq;
         check_eq("dout_i", dout_i, ei);
         check_eq("dout_q", dout_q, eq);
      end else begin
         check_eq("hold_i", dout_i, last_i);
         check_eq("hold_q", dout_q, last_q);
      end
   end

   initial begin
      junk_din();
      idle(3);
      @(negedge clk);
      rstn = 1'b1;
      idle(2);

      fill_ramp(0);
      send_frame(0, 1'b0);
      idle(40);

      send_frame(4, 1'b0);
      idle(40);

      fill_ramp(0);
      send_frame(0, 1'b0);
      fill_ramp(1000);
      send_frame(0, 1'b0);
      idle(40);

      fill_ramp(200);
      for (int b = 0; b < 10; b++) send_beat(b);
      do_reset(2);
      idle(3);
      fill_ramp(300);
      send_frame(0, 1'b0);
      idle(40);

      for (int n = 0; n < N; n++) begin
         cur_i[n] = 0;
         cur_q[n] = 0;
      end
      cur_i[0] = -4096;
      cur_i[511] = 4095;
      cur_q[0] = 4095;
      cur_q[511] = -4096;
      send_frame(0, 1'b0);
      idle(40);

      for (int f = 0; f < 3; f++) begin
         fill_rand();
         send_frame(0, 1'b1);
      end
      fill_rand();
      send_frame(0, 1'b0);
      idle(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
